change_dispenser: RTL and testbench

- Pays out a credit balance as physical coins: the output-side counterpart of the coin-accepting vending controller.
- On a start pulse it latches an amount and issues coins one at a time, greedy and largest denomination first, to a coin hopper over a valid/ack handshake.
- Tracks a per-denomination stock, reports any shortfall, and flags a hopper timeout.
- Sits between the vending FSM (which supplies the balance after a purchase) and the hopper actuator.

---
 rtl/change_dispenser.sv | 220 ++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a credit balance as coins. On an accepted start the amount is
//   latched and coins are issued one at a time, greedy and largest
//   denomination first, to a hopper over a valid/ack handshake. A stock count
//   is kept per denomination. A shortfall (no eligible coin left while a
//   balance remains) and a hopper ack timeout are both reported.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active low
//   start_i      one-cycle payout request, sampled only in IDLE
//   amount_i     balance to pay, latched on an accepted start
//   refill_i     reload every stock to INIT_STOCK, honoured only in IDLE
//   coin_ack_i   hopper has released the presented coin
//   coin_valid_o coin request to the hopper
//   coin_type_o  denomination index 0..3, stable while coin_valid_o is high
//   busy_o       high in every state except IDLE
//   done_o       one-cycle completion pulse
//   short_o      last payout stopped with a balance left because stock ran out
//   fault_o      last payout aborted on an ack timeout
//   remaining_o  unpaid balance
//   stock_o      stock counts {stock3, stock2, stock1, stock0}
//
// State table
//   state   | meaning
//   IDLE    | waiting for start or refill
//   SELECT  | pick the largest affordable denomination that is in stock
//   ISSUE   | coin presented to the hopper, waiting for ack or timeout
//   GAP     | idle spacing after an acked coin
//   DONE    | one-cycle completion pulse

module change_dispenser #(
  parameter int DENOM0      = 1,
  parameter int DENOM1      = 5,
  parameter int DENOM2      = 10,
  parameter int DENOM3      = 20,
  parameter int STOCK_W     = 6,
  parameter int INIT_STOCK  = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [7:0]           amount_i,
  input  logic                 refill_i,
  input  logic                 coin_ack_i,
  output logic                 coin_valid_o,
  output logic [1:0]           coin_type_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 short_o,
  output logic                 fault_o,
  output logic [7:0]           remaining_o,
  output logic [4*STOCK_W-1:0] stock_o
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         remaining_q, remaining_d;
  logic [1:0]         coin_type_q, coin_type_d;
  logic               short_q, short_d;
  logic               fault_q, fault_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];

  logic               sel_found;
  logic [1:0]         sel_k;

  function automatic logic [7:0] denom_of(input logic [1:0] k);
    logic [7:0] v;
    v = 8'(DENOM0);
    case (k)
      2'd0: v = 8'(DENOM0);
      2'd1: v = 8'(DENOM1);
      2'd2: v = 8'(DENOM2);
      2'd3: v = 8'(DENOM3);
      default: v = 8'(DENOM0);
    endcase
    return v;
  endfunction

  // Ascending scan: a later (larger) eligible denomination overrides an
  // earlier one, so the result is the highest affordable type in stock.
  always_comb begin
    sel_found = 1'b0;
    sel_k     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if ((denom_of(2'(k)) <= remaining_q) && (stock_q[k] != '0)) begin
        sel_found = 1'b1;
        sel_k     = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= 8'd0;
      coin_type_q <= 2'd0;
      short_q     <= 1'b0;
      fault_q     <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
      for (int k = 0; k < 4; k++) begin
        stock_q[k] <= STOCK_INIT;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_type_q <= coin_type_d;
      short_q     <= short_d;
      fault_q     <= fault_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      stock_q     <= stock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_type_d = coin_type_q;
    short_d     = short_q;
    fault_d     = fault_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    stock_d     = stock_q;

    case (state_q)
      S_IDLE: begin
        // start has priority; a simultaneous refill is dropped.
        if (start_i) begin
          remaining_d = amount_i;
          short_d     = 1'b0;
          fault_d     = 1'b0;
          state_d     = S_SELECT;
        end else if (refill_i) begin
          for (int k = 0; k < 4; k++) begin
            stock_d[k] = STOCK_INIT;
          end
        end
      end

      S_SELECT: begin
        tmo_d = '0;
        if (remaining_q == 8'd0) begin
          state_d = S_DONE;
        end else if (sel_found) begin
          coin_type_d = sel_k;
          state_d     = S_ISSUE;
        end else begin
          short_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_ISSUE: begin
        if (coin_ack_i) begin
          // Selection guaranteed denom <= remaining and stock > 0, so
          // neither subtraction can wrap.
          remaining_d          = remaining_q - denom_of(coin_type_q);
          stock_d[coin_type_q] = stock_q[coin_type_q] - STOCK_W'(1);
          tmo_d                = '0;
          gap_d                = GAP_LOAD;
          state_d              = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          // ACK_TIMEOUT cycles presented without an ack.
          fault_d = 1'b1;
          tmo_d   = '0;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign coin_valid_o = (state_q == S_ISSUE);
  assign coin_type_o  = coin_type_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign short_o      = short_q;
  assign fault_o      = fault_q;
  assign remaining_o  = remaining_q;
  assign stock_o      = {stock_q[3], stock_q[2], stock_q[1], stock_q[0]};

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int GAP  = 4;
  localparam int TMO  = 1000;
  localparam int SW   = 6;
  localparam int INIT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [7:0]    amount_i = 8'd0;
  logic          refill_i = 1'b0;
  logic          coin_ack_i = 1'b0;
  logic          coin_valid_o;
  logic [1:0]    coin_type_o;
  logic          busy_o;
  logic          done_o;
  logic          short_o;
  logic          fault_o;
  logic [7:0]    remaining_o;
  logic [4*SW-1:0] stock_o;

  always #5 clk = ~clk;

  change_dispenser #(
    .DENOM0(1), .DENOM1(5), .DENOM2(10), .DENOM3(20),
    .STOCK_W(SW), .INIT_STOCK(INIT), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .amount_i(amount_i),
    .refill_i(refill_i), .coin_ack_i(coin_ack_i),
    .coin_valid_o(coin_valid_o), .coin_type_o(coin_type_o),
    .busy_o(busy_o), .done_o(done_o), .short_o(short_o), .fault_o(fault_o),
    .remaining_o(remaining_o), .stock_o(stock_o)
  );

  int checks = 0;
  int failures = 0;

  int den[4] = '{1, 5, 10, 20};
  int model_stock[4];
  int exp_ns[4];
  int exp_coins[$];
  int obs[$];
  int exp_rem, exp_lat, exp_vcyc, exp_left;
  bit exp_short, exp_fault;

  bit armed = 0;
  bit txn = 0;
  bit ack_en = 1;
  int lat, vcnt, last_lat, last_vcnt;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int pack_ns();
    int p;
    p = 0;
    for (int k = 0; k < 4; k++) p = p | (exp_ns[k] << (k * SW));
    return p;
  endfunction

  function automatic int field(input int k);
    return int'(stock_o[k*SW +: SW]);
  endfunction

  // Greedy payout worked out per denomination, largest first.
  task automatic plan(input int amt, input bit ack);
    int r;
    int first;
    r = amt;
    exp_coins.delete();
    exp_ns = model_stock;
    for (int k = 3; k >= 0; k--) begin
      while (r >= den[k] && exp_ns[k] > 0) begin
        exp_coins.push_back(k);
        r = r - den[k];
        exp_ns[k] = exp_ns[k] - 1;
      end
    end
    if (!ack && exp_coins.size() > 0) begin
      first = exp_coins[0];
      exp_coins.delete();
      exp_coins.push_back(first);
      exp_ns    = model_stock;
      exp_rem   = amt;
      exp_short = 0;
      exp_fault = 1;
      exp_lat   = 2 + TMO;
      exp_vcyc  = TMO;
      exp_left  = 1;
    end else begin
      exp_rem   = r;
      exp_short = (r != 0);
      exp_fault = 0;
      exp_lat   = 2 + exp_coins.size() * (2 + GAP);
      exp_vcyc  = exp_coins.size();
      exp_left  = 0;
    end
  endtask

  // Compare process; also plays the hopper (acks on the cycle after valid).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        coin_ack_i = 1'b0;
      end else if (armed) begin
        armed = 0;
        txn   = 1;
        lat   = 0;
        vcnt  = 0;
        obs.delete();
        chk("busy_pre", busy_o, 0);
        coin_ack_i = 1'b0;
      end else if (txn) begin
        lat++;
        chk("busy", busy_o, 1);
        coin_ack_i = 1'b0;
        if (coin_valid_o) begin
          vcnt++;
          chk("coin_type", coin_type_o, exp_coins.size() > 0 ? exp_coins[0] : -1);
          if (ack_en) begin
            coin_ack_i = 1'b1;
            obs.push_back(int'(coin_type_o));
            if (exp_coins.size() > 0) void'(exp_coins.pop_front());
          end
        end
        if (done_o) begin
          chk("latency", lat, exp_lat);
          chk("remaining", remaining_o, exp_rem);
          chk("short", short_o, exp_short);
          chk("fault", fault_o, exp_fault);
          chk("stock", stock_o, pack_ns());
          chk("valid_cycles", vcnt, exp_vcyc);
          chk("coins_left", exp_coins.size(), exp_left);
          model_stock = exp_ns;
          last_lat  = lat;
          last_vcnt = vcnt;
          txn = 0;
        end
      end else begin
        coin_ack_i = 1'b0;
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_valid", coin_valid_o, 0);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 3000 && (armed || txn); i++) @(posedge clk);
    if (armed || txn) begin
      failures++;
      $display("FAIL done_timeout actual=busy required=done");
      armed = 0;
      txn   = 0;
    end
  endtask

  task automatic launch(input int amt, input bit ack, input bit refl);
    plan(amt, ack);
    ack_en = ack;
    @(posedge clk); #1;
    amount_i = 8'(amt);
    start_i  = 1'b1;
    refill_i = refl;
    armed    = 1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    refill_i = 1'b0;
  endtask

  task automatic run(input int amt, input bit ack, input bit refl);
    launch(amt, ack, refl);
    wait_done();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !coin_valid_o; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_valid", coin_valid_o, 1);
  endtask

  task automatic do_refill();
    @(posedge clk); #1;
    refill_i = 1'b1;
    @(posedge clk); #1;
    refill_i = 1'b0;
    for (int k = 0; k < 4; k++) model_stock[k] = INIT;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_valid"}, coin_valid_o, 0);
    chk({nm, "_type"}, coin_type_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_short"}, short_o, 0);
    chk({nm, "_fault"}, fault_o, 0);
    chk({nm, "_rem"}, remaining_o, 0);
    chk({nm, "_stock"}, stock_o, 24'h208208);
  endtask

  task automatic pin(input string nm, input int lit[$]);
    chk({nm, "_n"}, obs.size(), lit.size());
    for (int i = 0; i < lit.size(); i++)
      chk(nm, i < obs.size() ? obs[i] : -1, lit[i]);
  endtask

  initial begin
    int lit[$];
    for (int k = 0; k < 4; k++) model_stock[k] = INIT;

    #2 rst = 1'b0;
    #1 check_reset("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 37 from full stock: 20,10,5,1,1
    run(37, 1, 0);
    lit = '{3, 2, 1, 0, 0};
    pin("coins37", lit);
    chk("stock37", stock_o, 24'h1C71C6);
    chk("rem37", remaining_o, 0);

    // Empty the 20s, then 25 pays 10,10,5
    do_refill();
    chk("refill_stock", stock_o, 24'h208208);
    for (int i = 0; i < 8; i++) run(20, 1, 0);
    chk("stock3_empty", field(3), 0);
    run(25, 1, 0);
    lit = '{2, 2, 1};
    pin("coins25", lit);
    chk("short25", short_o, 0);

    // Drain to {0,0,0,1}, then 3 pays one coin and runs short by 2
    do_refill();
    run(255, 1, 0);
    run(32, 1, 0);
    chk("stock_0001", stock_o, 24'h000001);
    run(3, 1, 0);
    lit = '{0};
    pin("coins3", lit);
    chk("short3", short_o, 1);
    chk("rem3", remaining_o, 2);

    // Zero amount
    run(0, 1, 0);
    chk("lat0", last_lat, 2);
    chk("short0", short_o, 0);
    chk("fault0", fault_o, 0);

    // Hopper never acks
    do_refill();
    run(5, 0, 0);
    chk("fault5", fault_o, 1);
    chk("rem5", remaining_o, 5);
    chk("valid5", last_vcnt, TMO);
    chk("stock1_5", field(1), INIT);
    chk("lat5", last_lat, 2 + TMO);

    // Start, amount and refill while busy are ignored
    launch(37, 1, 0);
    wait_valid();
    start_i  = 1'b1;
    amount_i = 8'd99;
    refill_i = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    refill_i = 1'b0;
    wait_done();
    chk("busy_ign_stock", stock_o, 24'h1C71C6);
    chk("busy_ign_rem", remaining_o, 0);

    // start together with refill in IDLE: refill dropped
    run(1, 1, 1);
    chk("start_refill_stock", stock_o, 24'h1C71C5);

    // Reset while a coin is presented
    launch(20, 0, 0);
    wait_valid();
    rst = 1'b0;
    #1 check_reset("midrst");
    txn = 0;
    armed = 0;
    exp_coins.delete();
    for (int k = 0; k < 4; k++) model_stock[k] = INIT;
    ack_en = 1;
    @(posedge clk); #1 rst = 1'b1;

    run(16, 1, 0);
    lit = '{2, 1, 0};
    pin("coins16", lit);
    chk("stock16", stock_o, 24'h2071C7);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
